shift_sequencer: RTL and testbench

Controller that sequences a serial shift-register chain (a D input feeding a DEPTH-stage flop pipeline). It accepts a parallel word over a valid/ready handshake and streams its low `len` bits into the chain's serial input, LSB first, one bit per enabled cycle. It then appends DEPTH zero bits so that the last data bit reaches the final stage, and pulses `done`. It sits between a word-level producer and the shift-register datapath, and owns the chain's shift enable.

---
 rtl/shift_sequencer.sv | 135 +++++++++++++
 tb/tb_shift_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//    Feeds a DEPTH-stage serial shift-register chain from a word-level
//    producer. A parallel word is accepted over a valid/ready handshake, its
//    low len bits are streamed LSB first into the chain's D input (one bit per
//    enabled cycle), DEPTH zero bits follow so the last data bit reaches the
//    final stage, and a one-cycle done pulse marks completion. The block owns
//    the chain's shift enable.
//
// Ports:
//    clk       in   1      rising-edge clock
//    rst_n     in   1      asynchronous active-low reset
//    in_valid  in   1      producer offers a word
//    in_ready  out  1      controller can accept a word (IDLE only)
//    in_data   in   WIDTH  word to serialise, bit 0 sent first
//    in_len    in   LEN_W  number of bits to send, clamped to WIDTH
//    stall     in   1      freezes shifting/flushing while high
//    sr_d      out  1      serial data to the chain
//    sr_en     out  1      shift enable to the chain
//    busy      out  1      high whenever not IDLE
//    done      out  1      one-cycle pulse after the word has propagated
// -----------------------------------------------------------------------------
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             stall,
   output logic             sr_d,
   output logic             sr_en,
   output logic             busy,
   output logic             done
);

   // Flush counter must hold DEPTH itself; keep it at least one bit wide so
   // the DEPTH==0 build still elaborates (the counter is simply never loaded).
   localparam int FL_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(WIDTH);
   localparam logic [FL_W-1:0]  FLUSH_INIT = FL_W'(DEPTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] bits_left_q, bits_left_d;
   logic [FL_W-1:0]  flush_left_q, flush_left_d;

   // Next-state logic. Every counter and the shift register only move on an
   // enabled (non-stalled) edge, so a stall freezes the whole sequence and
   // simply stretches it by one cycle per stalled cycle. A zero-length word
   // skips straight to DONE so the chain is never touched.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bits_left_d  = bits_left_q;
      flush_left_d = flush_left_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_d     = in_data;
               bits_left_d = (in_len > LEN_MAX) ? LEN_MAX : in_len;
               state_d     = (in_len == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!stall) begin
               shreg_d     = shreg_q >> 1;
               bits_left_d = bits_left_q - LEN_W'(1);
               if (bits_left_q == LEN_W'(1)) begin
                  if (DEPTH == 0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d      = ST_FLUSH;
                     flush_left_d = FLUSH_INIT;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               flush_left_d = flush_left_q - FL_W'(1);
               if (flush_left_q == FL_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset discards any partially sent word; the chain
   // itself is outside this block and keeps whatever it already holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bits_left_q  <= '0;
         flush_left_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bits_left_q  <= bits_left_d;
         flush_left_q <= flush_left_d;
      end
   end

   // Outputs decode the registered state only (plus stall for the enable),
   // so reset takes effect on them immediately. sr_d keeps showing the
   // pending bit through a stall; only sr_en is gated.
   always_comb begin
      in_ready = (state_q == ST_IDLE);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      sr_en    = ((state_q == ST_SHIFT) || (state_q == ST_FLUSH)) && !stall;
      sr_d     = (state_q == ST_SHIFT) ? shreg_q[0] : 1'b0;
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Purpose:
//    Directed testbench for shift_sequencer (WIDTH=8, DEPTH=2). Drives words
//    through the handshake, watches the serial stream, enable, done and
//    handshake outputs cycle by cycle, and compares them against values
//    worked out from the word, its length and the stall pattern. A 2-stage
//    chain model sits on sr_d/sr_en to show data arriving at the last stage.
//
// Ports:
//    none (top-level bench)
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int LEN_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LEN_W-1:0] in_len;
   logic             stall;
   logic             sr_d;
   logic             sr_en;
   logic             busy;
   logic             done;

   logic chain_stage0 = 1'b0;
   logic chain_stage1 = 1'b0;

   int totalCount = 0;
   int badCount   = 0;

   shift_sequencer #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .LEN_W(LEN_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data (in_data),
      .in_len  (in_len),
      .stall   (stall),
      .sr_d    (sr_d),
      .sr_en   (sr_en),
      .busy    (busy),
      .done    (done)
   );

   // 10 ns clock; outputs are sampled just after the falling edge.
   always #5 clk = ~clk;

   // Downstream 2-stage chain: D feeds stage0, stage1 is the last stage.
   always @(posedge clk) begin
      if (sr_en) begin
         chain_stage1 <= chain_stage0;
         chain_stage0 <= sr_d;
      end
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      totalCount++;
      if (got !== exp) begin
         badCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Offers one word and returns just after the accept edge, with in_valid
   // dropped again.
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input int len);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      in_len   = LEN_W'(len);
      #1;
      checkOutput("ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Expected serial bit at enabled position idx: data bits, then flush zeros.
   function automatic logic expBit(input logic [WIDTH-1:0] data, input int lc,
                                   input int idx);
      if (idx < lc) return data[idx];
      return 1'b0;
   endfunction

   // Follows one word from cycle 1 after accept until the cycle after done.
   // Optional stall of stallCycles cycles once stallAfter bits have gone out.
   task automatic runWord(input logic [WIDTH-1:0] data, input int len,
                          input int stallAfter, input int stallCycles,
                          input bit checkChain);
      int  lc, expEn, expDone;
      int  enCount, stalled, doneCycle, doneCount, readyBusy;
      bit  finished;
      lc        = (len > WIDTH) ? WIDTH : len;
      expEn     = (lc == 0) ? 0 : lc + DEPTH;
      expDone   = (lc == 0) ? 1 : lc + DEPTH + 1 + stallCycles;
      enCount   = 0;
      stalled   = 0;
      doneCycle = 0;
      doneCount = 0;
      readyBusy = 0;
      finished  = 1'b0;
      for (int c = 1; c <= 60 && !finished; c++) begin
         @(negedge clk);
         stall = (enCount == stallAfter) && (stalled < stallCycles);
         #1;
         if (c == 1) checkOutput("busy_cycle1", {31'd0, busy}, 32'd1);
         if (checkChain && enCount == lc + 1 && !stall)
            checkOutput("chain_last", {31'd0, chain_stage1}, {31'd0, data[lc-1]});
         if (stall) begin
            stalled++;
            checkOutput("stall_en", {31'd0, sr_en}, 32'd0);
            checkOutput("stall_d", {31'd0, sr_d}, {31'd0, expBit(data, lc, enCount)});
         end
         if (sr_en) begin
            checkOutput($sformatf("bit%0d", enCount), {31'd0, sr_d},
                        {31'd0, expBit(data, lc, enCount)});
            enCount++;
         end
         if (in_ready && busy) readyBusy++;
         if (done) begin
            doneCount++;
            if (doneCycle == 0) doneCycle = c;
         end
         if (doneCycle != 0 && c == doneCycle + 1) begin
            checkOutput("ready_after_done", {31'd0, in_ready}, 32'd1);
            checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
            finished = 1'b1;
         end
      end
      stall = 1'b0;
      if (!finished) checkOutput("timeout", 32'd0, 32'd1);
      checkOutput("en_count", enCount, expEn);
      checkOutput("done_cycle", doneCycle, expDone);
      checkOutput("done_count", doneCount, 32'd1);
      checkOutput("ready_while_busy", readyBusy, 32'd0);
   endtask

   // Main sequence: reset, directed words, stall, mid-word reset, back-to-back.
   initial begin
      logic [19:0] seen;
      int          enIdx;
      int          doneFirst;
      int          doneSecond;
      int          acceptCycle;
      int          readyBusy;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = '0;
      stall    = 1'b0;
      #1;
      checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_en", {31'd0, sr_en}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_d", {31'd0, sr_d}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] full word 8'hB2 len 8");
      applyStimulus(8'hB2, 8);
      runWord(8'hB2, 8, -1, 0, 1'b1);

      $display("[TB] short word 8'hFF len 3");
      applyStimulus(8'hFF, 3);
      runWord(8'hFF, 3, -1, 0, 1'b0);

      $display("[TB] clamped word 8'hC3 len 12");
      applyStimulus(8'hC3, 12);
      runWord(8'hC3, 12, -1, 0, 1'b0);

      $display("[TB] zero-length word");
      applyStimulus(8'hA5, 0);
      runWord(8'hA5, 0, -1, 0, 1'b0);

      $display("[TB] 8'hB2 with 3-cycle stall after bit 4");
      applyStimulus(8'hB2, 8);
      runWord(8'hB2, 8, 4, 3, 1'b0);

      $display("[TB] reset during 5th shift cycle");
      applyStimulus(8'hB2, 8);
      repeat (4) @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("pre_rst_en", {31'd0, sr_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_en", {31'd0, sr_en}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
      checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h5A, 8);
      runWord(8'h5A, 8, -1, 0, 1'b0);

      $display("[TB] back-to-back 8'h01 then 8'h80");
      seen        = '0;
      enIdx       = 0;
      doneFirst   = 0;
      doneSecond  = 0;
      acceptCycle = 0;
      readyBusy   = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_len   = LEN_W'(8);
      @(posedge clk);
      for (int c = 1; c <= 40 && doneSecond == 0; c++) begin
         @(negedge clk);
         if (c == 1) in_data = 8'h80;
         if (acceptCycle != 0 && c == acceptCycle + 1) in_valid = 1'b0;
         #1;
         if (sr_en && enIdx < 20) begin
            seen[enIdx] = sr_d;
            enIdx++;
         end
         if (in_ready && busy) readyBusy++;
         if (in_ready && in_valid && acceptCycle == 0) acceptCycle = c;
         if (done && doneFirst == 0) doneFirst = c;
         else if (done && doneFirst != 0 && c > doneFirst) doneSecond = c;
      end
      in_valid = 1'b0;
      checkOutput("b2b_done1", doneFirst, 32'd11);
      checkOutput("b2b_accept", acceptCycle, 32'd12);
      checkOutput("b2b_done2", doneSecond, 32'd23);
      checkOutput("b2b_bits", {12'd0, seen}, 32'h0002_0001);
      checkOutput("b2b_en_count", enIdx, 32'd20);
      checkOutput("b2b_ready_busy", readyBusy, 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
